// File: rtl/usb_pkg.sv
// Shared USB types for the host-side transaction sequencers.
package usb_pkg;

   typedef enum logic [3:0] {
      PID_OUT   = 4'b0001,
      PID_DATA0 = 4'b0011,
      PID_DATA1 = 4'b1011,
      PID_ACK   = 4'b0010,
      PID_NAK   = 4'b1010,
      PID_STALL = 4'b1110
   } pid_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_TOKEN,
      ST_DATA,
      ST_RESP
   } out_trans_state_t;

endpackage

// File: rtl/resp_timer.sv
// Response-wait timer plus NAK / timeout retry counters for out_trans_ctrl.
// Counters saturate at their limit and are cleared only when a transaction starts.
module resp_timer #(
   parameter int TIMEOUT_CYCLES = 256,
   parameter int MAX_TIMEOUTS   = 8,
   parameter int MAX_NAKS       = 8
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic cnt_clr_i,
   input  logic tmr_clr_i,
   input  logic tmr_run_i,
   input  logic tmr_hold_i,
   input  logic nak_inc_i,
   input  logic to_inc_i,
   output logic timeout_o,
   output logic nak_last_o,
   output logic to_last_o
);
   localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
   localparam int NAK_W = $clog2(MAX_NAKS + 1);
   localparam int TO_W  = $clog2(MAX_TIMEOUTS + 1);

   logic [TMR_W-1:0] timer_q, timer_d;
   logic [NAK_W-1:0] nak_q, nak_d;
   logic [TO_W-1:0]  to_q, to_d;

   // A packet being decoded keeps the timer pinned at zero.
   always_comb begin
      timer_d = timer_q;
      if (tmr_clr_i) begin
         timer_d = '0;
      end else if (tmr_run_i) begin
         timer_d = tmr_hold_i ? '0 : timer_q + 1'b1;
      end
   end

   always_comb begin
      nak_d = nak_q;
      to_d  = to_q;
      if (cnt_clr_i) begin
         nak_d = '0;
         to_d  = '0;
      end else begin
         if (nak_inc_i && (nak_q != NAK_W'(MAX_NAKS))) nak_d = nak_q + 1'b1;
         if (to_inc_i && (to_q != TO_W'(MAX_TIMEOUTS))) to_d = to_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         timer_q <= '0;
         nak_q   <= '0;
         to_q    <= '0;
      end else begin
         timer_q <= timer_d;
         nak_q   <= nak_d;
         to_q    <= to_d;
      end
   end

   assign timeout_o  = tmr_run_i && !tmr_hold_i && (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));
   assign nak_last_o = (nak_q == NAK_W'(MAX_NAKS - 1));
   assign to_last_o  = (to_q == TO_W'(MAX_TIMEOUTS - 1));

endmodule

// File: rtl/out_trans_ctrl.sv
// Host-side USB OUT transaction sequencer with per-endpoint data toggles and retry on NAK/timeout.
// Define OUT_TRANS_STALL_EN to end a transaction on STALL; otherwise STALL is treated as silence.
module out_trans_ctrl
   import usb_pkg::*;
#(
   parameter  int NUM_EP         = 16,
   parameter  int TIMEOUT_CYCLES = 256,
   parameter  int MAX_TIMEOUTS   = 8,
   parameter  int MAX_NAKS       = 8,
   localparam int EP_W           = (NUM_EP > 1) ? $clog2(NUM_EP) : 1
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            start,
   input  logic [EP_W-1:0] endp,
   input  logic            toggle_clr,
   output logic            done,
   output logic            success,
   output logic            failure,
   output logic            stalled,
   input  logic            sent,
   output logic            send_OUT,
   output logic            send_DATA,
   output logic            data_pid,
   output logic [EP_W-1:0] tx_endp,
   input  logic            rec_start,
   input  logic            rec_ACK,
   input  logic            rec_NAK,
   input  logic            rec_STALL
);
   out_trans_state_t state_q, state_d;
   logic [NUM_EP-1:0] toggle_q, toggle_d;
   logic [EP_W-1:0]   tx_endp_q, tx_endp_d;
   logic send_out_q, send_out_d, send_data_q, send_data_d, data_pid_q, data_pid_d;
   logic done_q, done_d, success_q, success_d, failure_q, failure_d, stalled_q, stalled_d;
   logic in_resp, stall_in, ack_ev, stall_ev, nak_ev, to_ev, fail_ev, retry_ev;
   logic timeout_hit, nak_last, to_last;

`ifdef OUT_TRANS_STALL_EN
   assign stall_in = rec_STALL;
`else
   logic unused_stall;
   assign unused_stall = rec_STALL;
   assign stall_in     = 1'b0;
`endif

   // Same-cycle handshake priority: ACK > STALL > NAK > timeout.
   assign in_resp  = (state_q == ST_RESP);
   assign ack_ev   = in_resp && rec_ACK;
   assign stall_ev = in_resp && !rec_ACK && stall_in;
   assign nak_ev   = in_resp && !rec_ACK && !stall_in && rec_NAK;
   assign to_ev    = timeout_hit && !rec_ACK && !stall_in && !rec_NAK;
   assign fail_ev  = (nak_ev && nak_last) || (to_ev && to_last);
   assign retry_ev = (nak_ev && !nak_last) || (to_ev && !to_last);

   resp_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .MAX_TIMEOUTS  (MAX_TIMEOUTS),
      .MAX_NAKS      (MAX_NAKS)
   ) u_resp_timer (
      .clk_i     (clock),
      .rst_ni    (reset_n),
      .cnt_clr_i ((state_q == ST_IDLE) && start),
      .tmr_clr_i ((state_q == ST_DATA) && sent),
      .tmr_run_i (in_resp),
      .tmr_hold_i(rec_start),
      .nak_inc_i (nak_ev),
      .to_inc_i  (to_ev),
      .timeout_o (timeout_hit),
      .nak_last_o(nak_last),
      .to_last_o (to_last)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start) state_d = ST_TOKEN;
         ST_TOKEN: if (sent)  state_d = ST_DATA;
         ST_DATA:  if (sent)  state_d = ST_RESP;
         ST_RESP: begin
            if (ack_ev || stall_ev || fail_ev) state_d = ST_IDLE;
            else if (retry_ev)                 state_d = ST_TOKEN;
         end
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      send_out_d  = 1'b0;
      send_data_d = 1'b0;
      done_d      = 1'b0;
      success_d   = 1'b0;
      failure_d   = 1'b0;
      stalled_d   = 1'b0;
      data_pid_d  = data_pid_q;
      tx_endp_d   = tx_endp_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               send_out_d = 1'b1;
               tx_endp_d  = endp;
            end
         end
         ST_TOKEN: begin
            if (sent) begin
               send_data_d = 1'b1;
               data_pid_d  = toggle_q[tx_endp_q];
            end
         end
         ST_RESP: begin
            send_out_d = retry_ev;
            done_d     = ack_ev || stall_ev || fail_ev;
            success_d  = ack_ev;
            failure_d  = stall_ev || fail_ev;
            stalled_d  = stall_ev;
         end
         default: ;
      endcase
   end

   // A clear request overrides an ACK flip arriving in the same cycle.
   always_comb begin
      toggle_d = toggle_q;
      if (toggle_clr)  toggle_d = '0;
      else if (ack_ev) toggle_d[tx_endp_q] = ~toggle_q[tx_endp_q];
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         toggle_q    <= '0;
         tx_endp_q   <= '0;
         send_out_q  <= 1'b0;
         send_data_q <= 1'b0;
         data_pid_q  <= 1'b0;
         done_q      <= 1'b0;
         success_q   <= 1'b0;
         failure_q   <= 1'b0;
         stalled_q   <= 1'b0;
      end else begin
         toggle_q    <= toggle_d;
         tx_endp_q   <= tx_endp_d;
         send_out_q  <= send_out_d;
         send_data_q <= send_data_d;
         data_pid_q  <= data_pid_d;
         done_q      <= done_d;
         success_q   <= success_d;
         failure_q   <= failure_d;
         stalled_q   <= stalled_d;
      end
   end

   assign send_OUT  = send_out_q;
   assign send_DATA = send_data_q;
   assign data_pid  = data_pid_q;
   assign tx_endp   = tx_endp_q;
   assign done      = done_q;
   assign success   = success_q;
   assign failure   = failure_q;
   assign stalled   = stalled_q;

endmodule

// File: tb/tb_out_trans_ctrl.sv
// Randomised transaction-level bench for out_trans_ctrl against a scripted host/device model.
module tb_out_trans_ctrl;
   localparam int NUM_EP  = 16;
   localparam int TO_CYC  = 256;
   localparam int MAX_TO  = 8;
   localparam int MAX_NAK = 8;
   localparam int EP_W    = 4;
   localparam int K_ACK = 0, K_NAK = 1, K_TO = 2, K_STALL = 3;
`ifdef OUT_TRANS_STALL_EN
   localparam bit STALL_EN = 1'b1;
`else
   localparam bit STALL_EN = 1'b0;
`endif

   logic clock = 1'b0;
   logic reset_n, start, toggle_clr, sent, rec_start, rec_ACK, rec_NAK, rec_STALL;
   logic [EP_W-1:0] endp;
   logic done, success, failure, stalled, send_OUT, send_DATA, data_pid;
   logic [EP_W-1:0] tx_endp;

   int n_checks = 0;
   int n_errors = 0;
   int n_att;
   bit tog[NUM_EP];
   int q_kind[$], q_dly[$], q_hold[$];
   bit q_nak2[$], q_clr[$];

   out_trans_ctrl #(
      .NUM_EP(NUM_EP), .TIMEOUT_CYCLES(TO_CYC), .MAX_TIMEOUTS(MAX_TO), .MAX_NAKS(MAX_NAK)
   ) dut (
      .clock(clock), .reset_n(reset_n), .start(start), .endp(endp), .toggle_clr(toggle_clr),
      .done(done), .success(success), .failure(failure), .stalled(stalled), .sent(sent),
      .send_OUT(send_OUT), .send_DATA(send_DATA), .data_pid(data_pid), .tx_endp(tx_endp),
      .rec_start(rec_start), .rec_ACK(rec_ACK), .rec_NAK(rec_NAK), .rec_STALL(rec_STALL)
   );

   always #5 clock = ~clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clock);
   endtask

   function automatic logic sig(input int k);
      case (k)
         0:       return send_OUT;
         1:       return send_DATA;
         2:       return done;
         default: return send_OUT | done;
      endcase
   endfunction

   task automatic wait_for(input int k, input int limit, output int cyc);
      cyc = 0;
      while (!sig(k) && cyc < limit) begin
         tick();
         cyc++;
      end
      if (!sig(k)) chk($sformatf("wait_bound_%0d", k), sig(k), 1);
   endtask

   task automatic pulse_sent();
      sent = 1'b1;
      tick();
      sent = 1'b0;
   endtask

   task automatic push(input int k, input int d, input int h, input bit n2, input bit c);
      q_kind.push_back(k); q_dly.push_back(d); q_hold.push_back(h);
      q_nak2.push_back(n2); q_clr.push_back(c);
   endtask

   task automatic clear_model();
      for (int i = 0; i < NUM_EP; i++) tog[i] = 1'b0;
   endtask

   // Drive one complete transaction on ep, responding per the queued script.
   task automatic run_txn(input int ep);
      int naks, tos, cyc, kind, dly, hold, tot;
      bit fin, nak2, clr, seen, e_done, e_succ, e_fail, e_stall, e_retry;
      naks = 0; tos = 0; fin = 0; n_att = 0;
      endp = EP_W'(ep); start = 1'b1; tick(); start = 1'b0;
      wait_for(0, 8, cyc);
      chk("out_lat", cyc, 0);
      while (!fin) begin
         if (q_kind.size() > 0) begin
            kind = q_kind.pop_front(); dly = q_dly.pop_front(); hold = q_hold.pop_front();
            nak2 = q_nak2.pop_front(); clr = q_clr.pop_front();
         end else begin
            kind = K_ACK; dly = 2; hold = 0; nak2 = 0; clr = 0;
         end
         tick();
         chk("out_pulse", send_OUT, 0);
         repeat ($urandom_range(0, 3)) begin
            start = 1'($urandom_range(0, 1)); endp = EP_W'($urandom); tick();
         end
         start = 1'b0;
         pulse_sent();
         wait_for(1, 8, cyc);
         n_att++;
         chk("data_lat", cyc, 0);
         chk("data_pid", data_pid, tog[ep]);
         chk("tx_endp", tx_endp, ep);
         repeat ($urandom_range(0, 3)) tick();
         pulse_sent();
         tot = 0; seen = 0;
         e_succ = 0; e_stall = 0;
         if (kind == K_TO || (kind == K_STALL && !STALL_EN)) begin
            if (kind == K_STALL) begin
               repeat (dly) begin tick(); tot++; end
               rec_STALL = 1'b1; tick(); tot++; rec_STALL = 1'b0;
            end
            wait_for(3, TO_CYC + 50, cyc);
            tot += cyc;
            tos++;
            e_done = (tos == MAX_TO);
            e_fail = e_done; e_retry = !e_done;
            chk("to_cycles", tot, TO_CYC);
         end else begin
            if (hold > 0) begin
               rec_start = 1'b1;
               repeat (hold) begin tick(); seen |= send_OUT | done; end
               rec_start = 1'b0;
            end
            repeat (dly) begin tick(); seen |= send_OUT | done; end
            rec_ACK = (kind == K_ACK); rec_NAK = (kind == K_NAK) || nak2;
            rec_STALL = (kind == K_STALL); toggle_clr = clr;
            tick();
            rec_ACK = 1'b0; rec_NAK = 1'b0; rec_STALL = 1'b0; toggle_clr = 1'b0;
            chk("early_resp", seen, 0);
            if (kind == K_ACK) begin
               e_done = 1; e_succ = 1; e_fail = 0; e_retry = 0;
            end else if (kind == K_NAK) begin
               naks++;
               e_done = (naks == MAX_NAK); e_fail = e_done; e_retry = !e_done;
            end else begin
               e_done = 1; e_fail = 1; e_stall = 1; e_retry = 0;
            end
            if (clr) clear_model();
            else if (kind == K_ACK) tog[ep] = ~tog[ep];
         end
         chk("done", done, e_done);
         chk("success", success, e_succ);
         chk("failure", failure, e_fail);
         chk("stalled", stalled, e_stall);
         chk("retry_out", send_OUT, e_retry);
         fin = e_done;
      end
      tick();
      chk("done_pulse", done, 0);
      q_kind.delete(); q_dly.delete(); q_hold.delete(); q_nak2.delete(); q_clr.delete();
   endtask

   initial begin
      int cyc;
      bit seen;
      reset_n = 1'b0; start = 0; endp = '0; toggle_clr = 0; sent = 0;
      rec_start = 0; rec_ACK = 0; rec_NAK = 0; rec_STALL = 0;
      clear_model();
      tick(); tick();
      chk("rst_outs", {send_OUT, send_DATA, done, success, failure, stalled, data_pid}, 0);
      chk("rst_endp", tx_endp, 0);
      reset_n = 1'b1;
      tick();

      push(K_ACK, 9, 0, 0, 0);
      run_txn(3);
      chk("ep3_toggled", tog[3], 1);
      run_txn(3);

      for (int i = 0; i < 7; i++) push(K_NAK, $urandom_range(0, 10), 0, 0, 0);
      push(K_ACK, 4, 0, 0, 0);
      run_txn(7);
      chk("nak7_pairs", n_att, 8);

      for (int i = 0; i < 8; i++) push(K_NAK, $urandom_range(0, 10), 0, 0, 0);
      run_txn(7);
      chk("nak8_pairs", n_att, 8);
      run_txn(7);

      for (int i = 0; i < 8; i++) push(K_TO, 0, 0, 0, 0);
      run_txn(1);
      chk("to8_pairs", n_att, 8);

      push(K_ACK, 3, 300, 0, 0);
      run_txn(2);
      push(K_ACK, 1, 0, 0, 1);
      run_txn(2);
      run_txn(2);
      push(K_ACK, 5, 0, 1, 0);
      run_txn(4);
      push(K_STALL, 5, 0, 0, 0);
      push(K_ACK, 2, 0, 0, 0);
      run_txn(6);
      run_txn(6);

      push(K_ACK, 2, 0, 0, 0);
      run_txn(5);
      endp = 4'd5; start = 1'b1; tick(); start = 1'b0;
      wait_for(0, 8, cyc);
      tick(); pulse_sent();
      wait_for(1, 8, cyc);
      pulse_sent();
      repeat (5) tick();
      #2 reset_n = 1'b0;
      #1;
      chk("midrst_outs", {send_OUT, send_DATA, done, success, failure, stalled, data_pid}, 0);
      chk("midrst_endp", tx_endp, 0);
      clear_model();
      tick(); tick();
      reset_n = 1'b1;
      seen = 0;
      repeat (20) begin tick(); seen |= done | send_OUT; end
      chk("midrst_no_done", seen, 0);
      run_txn(5);

      for (int t = 0; t < 30; t++) begin
         int ep, nk, tc, r, k;
         bit term;
         ep = $urandom_range(0, NUM_EP - 1); nk = 0; tc = 0; term = 0;
         while (!term) begin
            r = $urandom_range(0, 99);
            k = (r < 40) ? K_ACK : (r < 88) ? K_NAK : (r < 92) ? K_TO : K_STALL;
            push(k, $urandom_range(0, 20),
                 (k < 2 && $urandom_range(0, 9) == 0) ? $urandom_range(1, 40) : 0,
                 (k == K_ACK) && ($urandom_range(0, 3) == 0),
                 (k == K_ACK) && ($urandom_range(0, 7) == 0));
            if (k == K_ACK) term = 1;
            else if (k == K_NAK) begin nk++; term = (nk == MAX_NAK); end
            else if (k == K_STALL && STALL_EN) term = 1;
            else begin tc++; term = (tc == MAX_TO); end
         end
         if ($urandom_range(0, 9) == 0) begin
            toggle_clr = 1'b1; tick(); toggle_clr = 1'b0;
            clear_model();
         end
         run_txn(ep);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
